// File: rtl/instr_encoder.sv
// Packs decoded load/store/branch fields into 32-bit RV64 words behind a 2-entry output FIFO.
// Optional feature macro: IMM_RANGE_CHECK_EN flags immediates that do not fit in 12 signed bits.
module instr_encoder #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_kind,
    input  logic [4:0]       in_rd,
    input  logic [4:0]       in_rs1,
    input  logic [4:0]       in_rs2,
    input  logic [2:0]       in_funct3,
    input  logic [63:0]      in_imm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_instr,
    output logic             out_err,
    output logic [CNT_W-1:0] enc_count
);

    localparam int DEPTH   = 2;
    localparam int ENTRY_W = 33;

    localparam logic [1:0] KIND_LOAD    = 2'b00;
    localparam logic [1:0] KIND_STORE   = 2'b01;
    localparam logic [1:0] KIND_ILLEGAL = 2'b10;
    localparam logic [1:0] KIND_BRANCH  = 2'b11;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    logic [11:0]        imm12;
    logic               imm_out_of_range;
    logic [31:0]        enc_instr;
    logic               enc_err;
    logic [ENTRY_W-1:0] enc_entry;

    logic               push;
    logic               pop;
    logic               wr_ptr_reg;
    logic               rd_ptr_reg;
    logic [1:0]         count_reg;
    logic [1:0]         count_next;
    logic [CNT_W-1:0]   enc_count_reg;
    logic [ENTRY_W-1:0] head_entry;

    assign imm12 = in_imm[11:0];

`ifdef IMM_RANGE_CHECK_EN
    assign imm_out_of_range = (in_imm != {{52{in_imm[11]}}, in_imm[11:0]});
`else
    logic unused_imm_high;
    assign unused_imm_high  = ^in_imm[63:12];
    assign imm_out_of_range = 1'b0;
`endif

    // Branch immediates are halfword offsets, so imm12 maps onto the usual B-type imm[12:1] slots.
    always_comb begin
        enc_instr = 32'h0000_0000;
        enc_err   = 1'b0;
        case (in_kind)
            KIND_LOAD: begin
                enc_instr = {imm12[11:0], in_rs1, in_funct3, in_rd, OPC_LOAD};
                enc_err   = imm_out_of_range;
            end
            KIND_STORE: begin
                enc_instr = {imm12[11:5], in_rs2, in_rs1, in_funct3, imm12[4:0], OPC_STORE};
                enc_err   = imm_out_of_range;
            end
            KIND_BRANCH: begin
                enc_instr = {imm12[11], imm12[9:4], in_rs2, in_rs1, in_funct3,
                             imm12[3:0], imm12[10], OPC_BRANCH};
                enc_err   = imm_out_of_range;
            end
            KIND_ILLEGAL: begin
                enc_instr = 32'h0000_0000;
                enc_err   = 1'b1;
            end
            default: begin
                enc_instr = 32'h0000_0000;
                enc_err   = 1'b1;
            end
        endcase
    end

    assign enc_entry = {enc_err, enc_instr};

    // Handshakes look only at registered occupancy, so out_ready never reaches in_ready.
    assign in_ready  = (count_reg < 2'd2);
    assign out_valid = (count_reg != 2'd0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    always_comb begin
        count_next = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + 2'd1;
            2'b01:   count_next = count_reg - 2'd1;
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_reg    <= 1'b0;
            rd_ptr_reg    <= 1'b0;
            count_reg     <= 2'd0;
            enc_count_reg <= '0;
        end else begin
            count_reg <= count_next;
            if (push) begin
                wr_ptr_reg <= ~wr_ptr_reg;
            end
            if (pop) begin
                rd_ptr_reg    <= ~rd_ptr_reg;
                enc_count_reg <= enc_count_reg + 1'b1;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : gen_entry
            logic [ENTRY_W-1:0] data_reg;
            logic               wr_en;

            assign wr_en = push && (wr_ptr_reg == 1'(gi));

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    data_reg <= '0;
                end else if (wr_en) begin
                    data_reg <= enc_entry;
                end
            end
        end
    endgenerate

    assign head_entry = rd_ptr_reg ? gen_entry[1].data_reg : gen_entry[0].data_reg;

    // Gate with out_valid so a drained FIFO never exposes a stale word.
    assign out_instr = out_valid ? head_entry[31:0] : 32'h0000_0000;
    assign out_err   = out_valid ? head_entry[32]   : 1'b0;
    assign enc_count = enc_count_reg;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: encodings, FIFO back-pressure, reset flush and streaming round-trip.
module tb_instr_encoder;

    localparam int CNT_W = 16;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       in_kind;
    logic [4:0]       in_rd;
    logic [4:0]       in_rs1;
    logic [4:0]       in_rs2;
    logic [2:0]       in_funct3;
    logic [63:0]      in_imm;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_instr;
    logic             out_err;
    logic [CNT_W-1:0] enc_count;

    int n_cmp;
    int n_bad;
    int exp_enc;

    instr_encoder #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_kind   (in_kind),
        .in_rd     (in_rd),
        .in_rs1    (in_rs1),
        .in_rs2    (in_rs2),
        .in_funct3 (in_funct3),
        .in_imm    (in_imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .out_err   (out_err),
        .enc_count (enc_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] kind, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [2:0] f3, input logic [63:0] imm);
        in_kind   = kind;
        in_rd     = rd;
        in_rs1    = rs1;
        in_rs2    = rs2;
        in_funct3 = f3;
        in_imm    = imm;
    endtask

    // Inverse of the encoder: recover imm[11:0] from an encoded word the way the decoder does.
    function automatic logic [11:0] imm_gen(input logic [31:0] w);
        logic [11:0] r;
        case (w[6:0])
            7'b0000011: r = w[31:20];
            7'b0100011: r = {w[31:25], w[11:7]};
            7'b1100011: r = {w[31], w[7], w[30:25], w[11:8]};
            default:    r = 12'h000;
        endcase
        return r;
    endfunction

    // Push one entry with the consumer stalled, check the head, then pop it.
    task automatic send_one(input string tag, input logic [1:0] kind, input logic [4:0] rd,
                            input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                            input logic [63:0] imm, input logic [31:0] exp_instr, input logic exp_err);
        out_ready = 1'b0;
        drive(kind, rd, rs1, rs2, f3, imm);
        in_valid = 1'b1;
        check({tag, "_pre_valid"}, 64'(out_valid), 64'd0);
        tick();
        in_valid = 1'b0;
        check({tag, "_valid"}, 64'(out_valid), 64'd1);
        check({tag, "_instr"}, 64'(out_instr), 64'(exp_instr));
        check({tag, "_err"}, 64'(out_err), 64'(exp_err));
        $display("txn %s: instr=%h err=%0d", tag, out_instr, out_err);
        out_ready = 1'b1;
        tick();
        exp_enc++;
        out_ready = 1'b0;
        check({tag, "_drained"}, 64'(out_valid), 64'd0);
        check({tag, "_count"}, 64'(enc_count), 64'(exp_enc));
    endtask

    logic [1:0]  v_kind [6];
    logic [4:0]  v_rd   [6];
    logic [4:0]  v_rs1  [6];
    logic [4:0]  v_rs2  [6];
    logic [2:0]  v_f3   [6];
    logic [63:0] v_imm  [6];
    logic [31:0] v_exp  [6];

    initial begin
        logic exp_wide_err;
        n_cmp   = 0;
        n_bad   = 0;
        exp_enc = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        drive(2'b00, 5'd0, 5'd0, 5'd0, 3'd0, 64'd0);

        v_kind[0] = 2'b00; v_rd[0] = 5'd1;  v_rs1[0] = 5'd3;  v_rs2[0] = 5'd0;  v_f3[0] = 3'd2; v_imm[0] = 64'd2047;    v_exp[0] = 32'h7FF1_A083;
        v_kind[1] = 2'b01; v_rd[1] = 5'd9;  v_rs1[1] = 5'd0;  v_rs2[1] = 5'd31; v_f3[1] = 3'd7; v_imm[1] = -64'sd2048;  v_exp[1] = 32'h81F0_7023;
        v_kind[2] = 2'b11; v_rd[2] = 5'd7;  v_rs1[2] = 5'd5;  v_rs2[2] = 5'd6;  v_f3[2] = 3'd1; v_imm[2] = -64'sd2;     v_exp[2] = 32'hFE62_9EE3;
        v_kind[3] = 2'b00; v_rd[3] = 5'd31; v_rs1[3] = 5'd31; v_rs2[3] = 5'd4;  v_f3[3] = 3'd0; v_imm[3] = -64'sd1;     v_exp[3] = 32'hFFFF_8F83;
        v_kind[4] = 2'b11; v_rd[4] = 5'd0;  v_rs1[4] = 5'd0;  v_rs2[4] = 5'd0;  v_f3[4] = 3'd5; v_imm[4] = 64'd1024;    v_exp[4] = 32'h0000_50E3;
        v_kind[5] = 2'b01; v_rd[5] = 5'd3;  v_rs1[5] = 5'd1;  v_rs2[5] = 5'd1;  v_f3[5] = 3'd2; v_imm[5] = 64'd31;      v_exp[5] = 32'h0010_AFA3;

        // Reset state
        tick();
        tick();
        rst_n = 1'b1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_instr", 64'(out_instr), 64'd0);
        check("rst_out_err", 64'(out_err), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_enc_count", 64'(enc_count), 64'd0);

        // Single encodings
        send_one("load", 2'b00, 5'd5, 5'd2, 5'd0, 3'd3, 64'd8, 32'h0081_3283, 1'b0);
        send_one("store", 2'b01, 5'd0, 5'd2, 5'd6, 3'd3, -64'sd16, 32'hFE61_3823, 1'b0);
        send_one("branch", 2'b11, 5'd0, 5'd1, 5'd2, 3'd0, 64'd4, 32'h0020_8463, 1'b0);
        send_one("illegal", 2'b10, 5'd5, 5'd2, 5'd6, 3'd3, 64'd8, 32'h0000_0000, 1'b1);
`ifdef IMM_RANGE_CHECK_EN
        exp_wide_err = 1'b1;
`else
        exp_wide_err = 1'b0;
`endif
        send_one("load_imm2048", 2'b00, 5'd1, 5'd0, 5'd0, 3'd0, 64'd2048, 32'h8000_0083, exp_wide_err);

        // Back-pressure: three loads against a stalled consumer
        out_ready = 1'b0;
        in_valid  = 1'b1;
        drive(2'b00, 5'd10, 5'd0, 5'd0, 3'd0, 64'd1);
        tick();
        check("bp_ready_after_1", 64'(in_ready), 64'd1);
        check("bp_head_a", 64'(out_instr), 64'h0010_0503);
        drive(2'b00, 5'd11, 5'd0, 5'd0, 3'd0, 64'd2);
        tick();
        check("bp_ready_after_2", 64'(in_ready), 64'd0);
        drive(2'b00, 5'd12, 5'd0, 5'd0, 3'd0, 64'd3);
        tick();
        check("bp_ready_held", 64'(in_ready), 64'd0);
        check("bp_head_stable", 64'(out_instr), 64'h0010_0503);
        out_ready = 1'b1;
        tick();
        exp_enc++;
        check("bp_head_b", 64'(out_instr), 64'h0020_0583);
        check("bp_ready_reopen", 64'(in_ready), 64'd1);
        tick();
        exp_enc++;
        in_valid = 1'b0;
        check("bp_head_c", 64'(out_instr), 64'h0030_0603);
        tick();
        exp_enc++;
        out_ready = 1'b0;
        check("bp_drained", 64'(out_valid), 64'd0);
        check("bp_enc_count", 64'(enc_count), 64'(exp_enc));
        $display("txn backpressure: enc_count=%0d", enc_count);

        // Reset with a full FIFO
        in_valid = 1'b1;
        drive(2'b00, 5'd13, 5'd0, 5'd0, 3'd0, 64'd4);
        tick();
        tick();
        in_valid = 1'b0;
        check("flush_full", 64'(in_ready), 64'd0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        exp_enc = 0;
        check("flush_valid", 64'(out_valid), 64'd0);
        check("flush_count", 64'(enc_count), 64'd0);
        check("flush_ready", 64'(in_ready), 64'd1);
        check("flush_instr", 64'(out_instr), 64'd0);
        out_ready = 1'b1;
        tick();
        tick();
        check("flush_no_stale", 64'(out_valid), 64'd0);
        check("flush_count_hold", 64'(enc_count), 64'd0);
        $display("txn flush: out_valid=%0d enc_count=%0d", out_valid, enc_count);

        // Streaming: one word per cycle, occupancy never above one
        out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            drive(v_kind[k], v_rd[k], v_rs1[k], v_rs2[k], v_f3[k], v_imm[k]);
            in_valid = 1'b1;
            tick();
            if (k > 0) exp_enc++;
            check($sformatf("stream%0d_valid", k), 64'(out_valid), 64'd1);
            check($sformatf("stream%0d_ready", k), 64'(in_ready), 64'd1);
            check($sformatf("stream%0d_instr", k), 64'(out_instr), 64'(v_exp[k]));
            check($sformatf("stream%0d_imm", k), 64'(imm_gen(out_instr)), 64'(v_imm[k][11:0]));
            check($sformatf("stream%0d_err", k), 64'(out_err), 64'd0);
            $display("txn stream%0d: instr=%h imm=%h", k, out_instr, imm_gen(out_instr));
        end
        in_valid = 1'b0;
        tick();
        exp_enc++;
        check("stream_drained", 64'(out_valid), 64'd0);
        check("stream_enc_count", 64'(enc_count), 64'(exp_enc));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
